// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: per-channel 2-flop sync, polarity normalisation and a
// 4-state filter FSM producing a clean level plus press/release pulses.
// Optional long-press detection is enabled by defining KEY_LONG_PRESS_EN.
module key_filter_multi #(
  parameter int CH_NUM     = 4,
  parameter int CNT_MAX    = 1000000,
  parameter int ACTIVE_LOW = 1,
  parameter int LONG_MAX   = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] in_i,
  output logic [CH_NUM-1:0] out_o,
  output logic [CH_NUM-1:0] press_o,
  output logic [CH_NUM-1:0] release_o,
  output logic [CH_NUM-1:0] long_press_o,
  output logic              any_down_o
);

  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CH_NUM-1:0] REL_LVL = (ACTIVE_LOW != 0) ? {CH_NUM{1'b1}} : {CH_NUM{1'b0}};

`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PRESS_CHK, DOWN, RELEASE_CHK} state_t;

  state_t            state_q [CH_NUM];
  state_t            state_d [CH_NUM];
  logic [CW-1:0]     cnt_q   [CH_NUM];
  logic [CW-1:0]     cnt_d   [CH_NUM];
  logic [CH_NUM-1:0] s1_q, s2_q, k;
  logic [CH_NUM-1:0] out_q, out_d, press_q, press_d, rel_q, rel_d;
  logic              any_q;

  // Sync flops reset to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= REL_LVL;
      s2_q <= REL_LVL;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
    end
  end

  assign k = s2_q ^ REL_LVL;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      press_d[i] = 1'b0;
      rel_d[i]   = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (k[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = CW'(1);
          end else begin
            cnt_d[i] = '0;
          end
        end
        PRESS_CHK: begin
          if (!k[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = DOWN;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        DOWN: begin
          if (!k[i]) begin
            state_d[i] = RELEASE_CHK;
            cnt_d[i]   = CW'(1);
          end else begin
            cnt_d[i] = '0;
          end
        end
        RELEASE_CHK: begin
          if (k[i]) begin
            state_d[i] = DOWN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            rel_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      out_d[i] = (state_d[i] == DOWN) || (state_d[i] == RELEASE_CHK);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      out_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      out_q   <= out_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      any_q   <= |out_d;
    end
  end

  assign out_o      = out_q;
  assign press_o    = press_q;
  assign release_o  = rel_q;
  assign any_down_o = any_q;

  // Hold counter restarts only on an accepted press, so a release bounce back into
  // DOWN cannot re-arm the long-press pulse.
  if (LONG_EN) begin : g_long
    localparam int HW = $clog2(LONG_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MAX - 1);

    logic [HW-1:0]     hold_q [CH_NUM];
    logic [CH_NUM-1:0] fired_q, long_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < CH_NUM; i++) hold_q[i] <= '0;
        fired_q <= '0;
        long_q  <= '0;
      end else begin
        for (int i = 0; i < CH_NUM; i++) begin
          long_q[i] <= 1'b0;
          if (press_d[i]) begin
            hold_q[i]  <= '0;
            fired_q[i] <= 1'b0;
          end else if (state_q[i] == DOWN || state_q[i] == RELEASE_CHK) begin
            if (hold_q[i] != HOLD_LAST) begin
              hold_q[i] <= hold_q[i] + HW'(1);
            end else if (!fired_q[i]) begin
              long_q[i]  <= 1'b1;
              fired_q[i] <= 1'b1;
            end
          end
        end
      end
    end

    assign long_press_o = long_q;
  end else begin : g_no_long
    assign long_press_o = '0;
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Scoreboard bench for key_filter_multi: a window-based reference model predicts
// level and pulse events; a negedge monitor pops and compares them.
module tb_key_filter_multi;
  localparam int CH = 4;
  localparam int CM = 8;
  localparam int AL = 1;
  localparam int LM = 20;
  localparam logic [CH-1:0] REL = 4'hF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] in_r = 4'hF;
  logic [CH-1:0] out_w, press_w, rel_w, long_w;
  logic          any_w;

  key_filter_multi #(
    .CH_NUM(CH), .CNT_MAX(CM), .ACTIVE_LOW(AL), .LONG_MAX(LM)
  ) dut (
    .clk(clk), .rst(rst), .in_i(in_r),
    .out_o(out_w), .press_o(press_w), .release_o(rel_w),
    .long_press_o(long_w), .any_down_o(any_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [CH-1:0] p;
    logic [CH-1:0] r;
    logic [CH-1:0] l;
  } ev_t;

  ev_t           evq[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [CH-1:0] hist [0:8191];
  logic [CH-1:0] lvl = '0;
  int            press_cyc [CH];

  initial begin
    for (int i = 0; i < 8192; i++) hist[i] = REL;
    for (int c = 0; c < CH; c++) press_cyc[c] = 0;
  end

  // Reference model: a level flips once the last CM synchronised samples all
  // disagree with it; the synchroniser shows the raw value two edges later.
  always @(posedge clk) begin : model
    ev_t           e;
    logic [CH-1:0] nl;
    bit            flip;
    logic          pr;
    int            idx;
    cyc = cyc + 1;
    hist[cyc] = in_r;
    if (!rst) begin
      hist[cyc]     = REL;
      hist[cyc - 1] = REL;
      lvl = '0;
    end else begin
      e.cyc = cyc;
      e.p = '0;
      e.r = '0;
      e.l = '0;
      nl = lvl;
      for (int c = 0; c < CH; c++) begin
        flip = 1'b1;
        for (int j = 0; j < CM; j++) begin
          idx = cyc - 2 - j;
          pr = (idx < 0) ? 1'b0 : (hist[idx][c] != REL[c]);
          if (pr == lvl[c]) flip = 1'b0;
        end
`ifdef KEY_LONG_PRESS_EN
        if (lvl[c] && (cyc - press_cyc[c] == LM)) e.l[c] = 1'b1;
`endif
        if (flip) begin
          nl[c] = ~lvl[c];
          if (nl[c]) begin
            e.p[c] = 1'b1;
            press_cyc[c] = cyc;
          end else begin
            e.r[c] = 1'b1;
          end
        end
      end
      lvl = nl;
      if ((e.p | e.r | e.l) != '0) evq.push_back(e);
    end
  end

  always @(negedge clk) begin : monitor
    ev_t e;
    if (cyc > 0) begin
      total++;
      if (out_w !== lvl) begin
        bad++;
        $display("FAIL out cyc=%0d got=%h want=%h", cyc, out_w, lvl);
      end
      total++;
      if (any_w !== (|lvl)) begin
        bad++;
        $display("FAIL any_down cyc=%0d got=%b want=%b", cyc, any_w, |lvl);
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        total++;
        bad++;
        $display("FAIL stale_event cyc=%0d got=none want_cyc=%0d", cyc, e.cyc);
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        total++;
        if (press_w !== e.p || rel_w !== e.r || long_w !== e.l) begin
          bad++;
          $display("FAIL event cyc=%0d got p=%h r=%h l=%h want p=%h r=%h l=%h",
                   cyc, press_w, rel_w, long_w, e.p, e.r, e.l);
        end
      end else if ((press_w | rel_w | long_w) !== '0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got p=%h r=%h l=%h want none",
                 cyc, press_w, rel_w, long_w);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b0;
    in_r = 4'hF;
    step(3);
    rst = 1'b1;
    step(20);
    // single press on channel 0
    in_r[0] = 1'b0;
    step(20);
    // bouncing channel 1, then settle pressed
    for (int k = 0; k < 40; k++) begin
      in_r[1] = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    in_r[1] = 1'b0;
    step(20);
    // release channel 0, then simultaneous press of 2 and 3
    in_r[0] = 1'b1;
    step(20);
    in_r[2] = 1'b0;
    in_r[3] = 1'b0;
    step(20);
    // reset while channels are held down
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(20);
    // glitch boundaries: CM-1 samples rejected, CM samples accepted
    in_r = 4'hF;
    step(20);
    in_r[0] = 1'b0;
    step(CM - 1);
    in_r[0] = 1'b1;
    step(20);
    in_r[0] = 1'b0;
    step(CM);
    in_r[0] = 1'b1;
    step(20);
    // long hold on channel 0
    in_r[0] = 1'b0;
    step(50);
    in_r[0] = 1'b1;
    step(20);
    // randomised bouncing with occasional resets
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 11) == 0) in_r[c] = ~in_r[c];
      rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    rst  = 1'b1;
    in_r = 4'hF;
    step(30);
    total++;
    if (evq.size() != 0) begin
      bad++;
      $display("FAIL leftover_events got=%0d want=0", evq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
